// File: rtl/mode_counter_pkg.sv
// mode_counter_pkg: mode encodings and per-mode sequence length for mode_counter
package mode_counter_pkg;
  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_GRAY = 2'b01;
  localparam logic [1:0] MODE_JOHN = 2'b10;
  localparam logic [1:0] MODE_RING = 2'b11;
  function automatic int state_count(input logic [1:0] mode, input int width, input int mod);
    return mode == MODE_BIN ? mod : mode == MODE_GRAY ? 1 << width : mode == MODE_JOHN ? 2 * width : width;
  endfunction
endpackage

// File: rtl/mode_counter_cnt_encode.sv
// cnt_encode: maps sequence index and mode to the encoded output pattern
module cnt_encode
  import mode_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] john;
  // Johnson fills ones from the LSB, then drains them from the LSB
  assign john = 32'(i) < WIDTH ? (WIDTH'(1) << i) - WIDTH'(1)
                               : ~((WIDTH'(1) << (32'(i) - WIDTH)) - WIDTH'(1));
  assign q = mode == MODE_BIN  ? i :
             mode == MODE_GRAY ? i ^ (i >> 1) :
             mode == MODE_JOHN ? john : WIDTH'(1) << i;
endmodule

// File: rtl/mode_counter.sv
// mode_counter: multi-mode up/down sequence counter with load, terminal count and wrap/error pulses
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 2**WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             c,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             err
);
  if (WIDTH < 2 || WIDTH > 16 || MOD < 2 || MOD > 2**WIDTH) begin : g_bad_param
    $error("mode_counter: WIDTH or MOD out of range");
  end
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] i, i_d, last;
  logic             wrap_d, err_d;
  int               s_q, s_d;
  assign s_q  = state_count(mode_q, WIDTH, MOD);
  assign s_d  = state_count(mode, WIDTH, MOD);
  assign last = WIDTH'(s_q - 1);
  assign tc   = dir ? i == last : i == '0;
  always_comb begin
    mode_d = mode_q;
    i_d    = i;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      mode_d = mode;
      err_d  = 32'(d) >= s_d;
      i_d    = err_d ? '0 : d;
    end else if (mode != mode_q) begin
      mode_d = mode;
      i_d    = '0;
    end else if (c) begin
      wrap_d = tc;
      i_d    = dir ? (tc ? '0 : i + WIDTH'(1)) : (tc ? last : i - WIDTH'(1));
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mode_q <= MODE_BIN;
      i      <= '0;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else begin
      mode_q <= mode_d;
      i      <= i_d;
      wrap   <= wrap_d;
      err    <= err_d;
    end
  cnt_encode #(.WIDTH(WIDTH)) u_enc (.mode(mode_q), .i(i), .q(q));
endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: directed checks of mode_counter at WIDTH=4, MOD=10
module tb_mode_counter;
  logic clk = 1'b0, reset_n = 1'b0, c = 1'b0, dir = 1'b1, load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] d = 4'd0, q;
  logic tc, wrap, err;
  int errors = 0, checks = 0;
  logic [3:0] jt [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
  mode_counter #(.WIDTH(4), .MOD(10)) dut (
    .clk(clk), .reset_n(reset_n), .c(c), .dir(dir), .mode(mode), .load(load), .d(d),
    .q(q), .tc(tc), .wrap(wrap), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    check("rst_q", q, 0);
    check("rst_tc_up", tc, 0);
    check("rst_wrap", wrap, 0);
    check("rst_err", err, 0);
    dir = 1'b0;
    #1 check("rst_tc_dn", tc, 1);
    dir = 1'b1;
    #9 reset_n = 1'b1;
    c = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("bin_q%0d", k), q, 16'(k % 10));
      check($sformatf("bin_tc%0d", k), tc, 16'(k % 10 == 9));
      check($sformatf("bin_wrap%0d", k), wrap, 16'(k == 10));
    end
    repeat (5) tick();
    check("bin_q7", q, 7);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_q", q, 0);
    check("midrst_wrap", wrap, 0);
    check("midrst_err", err, 0);
    #3 reset_n = 1'b1;
    mode = 2'b01;
    tick();
    check("gray_sw_q", q, 0);
    check("gray_sw_wrap", wrap, 0);
    dir = 1'b0;
    #1 check("gray_tc0", tc, 1);
    tick();
    check("gray_q15", q, 4'b1000);
    check("gray_wrap", wrap, 1);
    check("gray_tc15", tc, 0);
    tick();
    check("gray_q14", q, 4'b1001);
    check("gray_wrap_clr", wrap, 0);
    mode = 2'b10;
    dir = 1'b1;
    tick();
    check("john_sw_q", q, 0);
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("john_q%0d", k), q, jt[k]);
      check($sformatf("john_wrap%0d", k), wrap, 16'(k == 7));
      check($sformatf("john_tc%0d", k), tc, 16'(k == 6));
    end
    mode = 2'b11;
    load = 1'b1;
    d = 4'd5;
    c = 1'b0;
    tick();
    check("ring_bad_q", q, 4'b0001);
    check("ring_err", err, 1);
    d = 4'd2;
    c = 1'b1;
    tick();
    check("ring_ld_q", q, 4'b0100);
    check("ring_err_clr", err, 0);
    check("ring_nowrap", wrap, 0);
    load = 1'b0;
    c = 1'b0;
    tick();
    check("ring_hold", q, 4'b0100);
    mode = 2'b00;
    load = 1'b1;
    d = 4'd6;
    tick();
    check("bin_ld6", q, 6);
    check("bin_ld6_err", err, 0);
    load = 1'b0;
    mode = 2'b10;
    c = 1'b1;
    tick();
    check("sw_john_q", q, 0);
    check("sw_john_wrap", wrap, 0);
    tick();
    check("sw_john_next", q, 4'b0001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
